// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioner.
// Optional auto-repeat is enabled by defining BUTTON_AUTO_REPEAT_EN.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } repeat_state_t;

   localparam int BTN_C = 0;
   localparam int BTN_N = 1;
   localparam int BTN_S = 2;
   localparam int BTN_E = 3;
   localparam int BTN_W = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw inputs in, conditioned levels and pulses out.
interface button_conditioner_if #(
   parameter int NUM_BTNS = 5
);
   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] btn_level;
   logic [NUM_BTNS-1:0] btn_press;
   logic [NUM_BTNS-1:0] btn_release;
   logic [NUM_BTNS-1:0] btn_step;

   modport master (
      output btn_raw,
      input  btn_level, btn_press, btn_release, btn_step
   );

   modport slave (
      input  btn_raw,
      output btn_level, btn_press, btn_release, btn_step
   );
endinterface

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce filter, edge pulses and
// (when BUTTON_AUTO_REPEAT_EN is defined) an auto-repeat step generator.
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_step
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_err
      $error("button_channel: cycle parameters must be >= 1");
   end

   logic [1:0]      sync_q, sync_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic            release_q, release_d;
   logic            step_q, step_d;
   logic            rpt_pulse;

   // NOTE: every signal gets a default before any branch, so no path leaves a
   // combinational output unassigned and no latch is inferred.
   always_comb begin
      sync_d    = {sync_q[0], btn_raw};
      db_cnt_d  = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync_q[1] != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_d   = sync_q[1];
            press_d   = sync_q[1];
            release_d = ~sync_q[1];
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_DELAY  = DELAY;
   localparam logic [1:0] ST_REPEAT = REPEAT;

   logic [1:0]       state_q, state_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

   // Release has priority so a terminal count on the release cycle is dropped.
   always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_pulse = 1'b0;
      if (release_d) begin
         state_d   = ST_IDLE;
         rpt_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rpt_cnt_d = '0;
               if (press_d) state_d = ST_DELAY;
            end
            ST_DELAY: begin
               if (rpt_cnt_q == DELAY_LAST) begin
                  rpt_pulse = 1'b1;
                  rpt_cnt_d = '0;
                  state_d   = ST_REPEAT;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
               end
            end
            ST_REPEAT: begin
               if (rpt_cnt_q == RATE_LAST) begin
                  rpt_pulse = 1'b1;
                  rpt_cnt_d = '0;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               rpt_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rpt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rpt_cnt_q <= rpt_cnt_d;
      end
   end
`else
   assign rpt_pulse = 1'b0;
`endif

   assign step_d = press_d | rpt_pulse;

   // NOTE: non-blocking assignments let every flop sample pre-edge values,
   // which is what makes the two sync stages a real two-cycle pipeline.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         step_q    <= step_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_step    = step_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner top: one independent button_channel per button.
// Auto-repeat steps are built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner
   import button_pkg::*;
#(
   parameter int NUM_BTNS        = 5,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic                 clk_50,
   input  logic                 rst_n,
   button_conditioner_if.slave  btn_if
);

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_chan (
         .clk_50      (clk_50),
         .rst_n       (rst_n),
         .btn_raw     (btn_if.btn_raw[i]),
         .btn_level   (btn_if.btn_level[i]),
         .btn_press   (btn_if.btn_press[i]),
         .btn_release (btn_if.btn_release[i]),
         .btn_step    (btn_if.btn_step[i])
      );
   end

endmodule
